// File: rtl/aemb_dwb_pkg.sv
// Shared definitions for the AEMB data wishbone arbiter: FSM state encodings
// and the data/select bus widths.
package aemb_dwb_pkg;

  localparam int unsigned DWB_DW = 32;
  localparam int unsigned DWB_SW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } dwb_state_e;

endpackage

// File: rtl/aemb_dwb_wdog.sv
// Transaction watchdog counter. It is held at zero while i_clr is high and
// advances while i_run is high. The parent decodes the terminal count.
module aemb_dwb_wdog #(
  parameter int unsigned TMO_W = 8
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             i_clr,
  input  logic             i_run,
  output logic [TMO_W-1:0] o_cnt
);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/aemb_dwb_arbiter.sv
// Two-master arbiter for the AEMB data wishbone bus. A grant is held from strobe to ack.
// The optional watchdog is enabled by defining AEMB_DWB_TIMEOUT_EN.
module aemb_dwb_arbiter
  import aemb_dwb_pkg::*;
#(
  parameter int unsigned AW    = 30,
  parameter int unsigned TMO_W = 8
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DWB_DW-1:0] m0_dat_i,
  input  logic [DWB_SW-1:0] m0_sel_i,
  input  logic              m0_stb_i,
  input  logic              m0_wre_i,
  output logic [DWB_DW-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DWB_DW-1:0] m1_dat_i,
  input  logic [DWB_SW-1:0] m1_sel_i,
  input  logic              m1_stb_i,
  input  logic              m1_wre_i,
  output logic [DWB_DW-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DWB_DW-1:0] s_dat_o,
  output logic [DWB_SW-1:0] s_sel_o,
  output logic              s_stb_o,
  output logic              s_wre_o,
  input  logic [DWB_DW-1:0] s_dat_i,
  input  logic              s_ack_i
);

  dwb_state_e       r_state;
  dwb_state_e       w_state_d;
  logic             r_last;
  logic             w_last_d;
  logic             w_busy;
  logic             w_term;
  logic             w_tmo;
  logic [TMO_W-1:0] w_cnt;

  assign w_busy = (r_state == StBusy0) || (r_state == StBusy1);

`ifdef AEMB_DWB_TIMEOUT_EN
  // Counter sits at zero in IDLE, so every BUSY entry starts from a cleared count.
  aemb_dwb_wdog #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .gclk  (gclk),
    .grst  (grst),
    .i_clr (~w_busy),
    .i_run (w_busy & ~s_ack_i),
    .o_cnt (w_cnt)
  );
`else
  assign w_cnt = '0;
`endif

  assign w_term = &w_cnt;
  // An ack on the terminal-count cycle completes normally.
  assign w_tmo  = w_busy & w_term & ~s_ack_i;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: begin
        // On a tie, grant the master that was not served last.
        if (m0_stb_i && (!m1_stb_i || r_last)) begin
          w_state_d = StBusy0;
          w_last_d  = 1'b0;
        end else if (m1_stb_i) begin
          w_state_d = StBusy1;
          w_last_d  = 1'b1;
        end
      end
      StBusy0: begin
        if (!m0_stb_i || s_ack_i || w_tmo) begin
          w_state_d = StIdle;
        end
      end
      StBusy1: begin
        if (!m1_stb_i || s_ack_i || w_tmo) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_stb_o  = 1'b0;
    s_wre_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (r_state)
      StBusy0: begin
        s_stb_o  = m0_stb_i & ~w_tmo;
        s_wre_o  = m0_wre_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = w_tmo;
      end
      StBusy1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i & ~w_tmo;
        s_wre_o  = m1_wre_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = w_tmo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aemb_dwb_arbiter.sv
// Directed bench for aemb_dwb_arbiter: cycle vector table plus hand sequences for
// reset, abort and (with AEMB_DWB_TIMEOUT_EN) the watchdog.
module tb_aemb_dwb_arbiter;

  localparam int unsigned AW = 30;
  localparam logic [AW-1:0] A0 = 30'h0000_0100;
  localparam logic [AW-1:0] A1 = 30'h0000_0200;
  localparam logic [31:0]   D0 = 32'h1111_0000;
  localparam logic [31:0]   D1 = 32'h2222_0000;
  localparam logic [31:0]   SD = 32'hDEAD_BEEF;

  logic          gclk = 1'b0;
  logic          grst = 1'b1;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_stb_i = 1'b0, m0_wre_i = 1'b0, m1_stb_i = 1'b0, m1_wre_i = 1'b0;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_stb_o, s_wre_o;
  logic          s_ack_i = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 gclk = ~gclk;

  aemb_dwb_arbiter #(
    .AW    (AW),
    .TMO_W (4)
  ) dut (
    .gclk     (gclk),
    .grst     (grst),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_stb_i (m0_stb_i),
    .m0_wre_i (m0_wre_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_stb_i (m1_stb_i),
    .m1_wre_i (m1_wre_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_stb_o  (s_stb_o),
    .s_wre_o  (s_wre_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i)
  );

  // g: 0 = idle, 1 = m0 granted, 2 = m1 granted
  typedef struct {
    logic       m0s, m0w, m1s, m1w, ack;
    logic [1:0] g;
    logic       es, ew, ea0, ea1;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic m0s, logic m0w, logic m1s, logic m1w, logic ack,
                              logic [1:0] g, logic es, logic ew, logic ea0, logic ea1);
    vec_t v;
    v.m0s = m0s; v.m0w = m0w; v.m1s = m1s; v.m1w = m1w; v.ack = ack;
    v.g = g; v.es = es; v.ew = ew; v.ea0 = ea0; v.ea1 = ea1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic m0s, input logic m0w, input logic m1s, input logic m1w,
                       input logic ack);
    m0_stb_i = m0s; m0_wre_i = m0w; m1_stb_i = m1s; m1_wre_i = m1w; s_ack_i = ack;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("vec%0d", i);
    check({p, " s_stb"}, {31'd0, s_stb_o}, {31'd0, v.es});
    check({p, " s_wre"}, {31'd0, s_wre_o}, {31'd0, v.ew});
    check({p, " s_adr"}, {2'd0, s_adr_o}, {2'd0, (v.g == 2'd2) ? A1 : A0});
    check({p, " s_dat"}, s_dat_o, (v.g == 2'd2) ? D1 : D0);
    check({p, " m0_ack"}, {31'd0, m0_ack_o}, {31'd0, v.ea0});
    check({p, " m1_ack"}, {31'd0, m1_ack_o}, {31'd0, v.ea1});
    check({p, " m0_dat"}, m0_dat_o, (v.g == 2'd1) ? SD : 32'd0);
    check({p, " m1_dat"}, m1_dat_o, (v.g == 2'd2) ? SD : 32'd0);
    check({p, " err"}, {30'd0, m1_err_o, m0_err_o}, 32'd0);
  endtask

  initial begin
    // m0s m0w m1s m1w ack | g es ew ea0 ea1
    vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // tie from reset
    vecs[1]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 1, 0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 1, 2, 1, 1, 0, 1);
    vecs[4]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); // repeat tie
    vecs[5]  = mk(1, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    vecs[6]  = mk(1, 0, 1, 1, 1, 1, 1, 0, 1, 0);
    vecs[7]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 1, 1, 2, 1, 1, 0, 1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // m0 read, ack 2 cycles late
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // spurious ack
    vecs[15] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0); // m1 back-to-back writes
    vecs[16] = mk(0, 0, 1, 1, 1, 2, 1, 1, 0, 1);
    vecs[17] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 1, 1, 1, 2, 1, 1, 0, 1);
    vecs[19] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 0, 2, 1, 1, 0, 0);
    vecs[21] = mk(0, 0, 1, 1, 1, 2, 1, 1, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // m0 write, aborted
    vecs[24] = mk(1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    vecs[25] = mk(1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[27] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[28] = mk(0, 0, 1, 0, 1, 2, 1, 0, 0, 1);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    m0_adr_i = A0; m1_adr_i = A1; m0_dat_i = D0; m1_dat_i = D1;
    m0_sel_i = 4'hF; m1_sel_i = 4'h3; s_dat_i = SD;

    // Reset state
    repeat (2) @(negedge gclk);
    drive(1, 1, 1, 1, 1);
    #1;
    check("reset s_stb", {31'd0, s_stb_o}, 32'd0);
    check("reset s_wre", {31'd0, s_wre_o}, 32'd0);
    check("reset acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    check("reset errs", {30'd0, m1_err_o, m0_err_o}, 32'd0);
    @(negedge gclk);
    drive(0, 0, 0, 0, 0);
    grst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      @(negedge gclk);
      drive(vecs[i].m0s, vecs[i].m0w, vecs[i].m1s, vecs[i].m1w, vecs[i].ack);
      #1;
      check_vec(i, vecs[i]);
    end

    // Async reset while BUSY1 is strobing
    @(negedge gclk);
    drive(0, 0, 1, 1, 0);
    @(negedge gclk);
    #1;
    check("rst pre s_stb", {31'd0, s_stb_o}, 32'd1);
    check("rst pre s_adr", {2'd0, s_adr_o}, {2'd0, A1});
    s_ack_i = 1'b1;
    grst = 1'b1;
    #1;
    check("rst async s_stb", {31'd0, s_stb_o}, 32'd0);
    check("rst async m1_ack", {31'd0, m1_ack_o}, 32'd0);
    check("rst async m1_dat", m1_dat_o, 32'd0);
    @(negedge gclk);
    grst = 1'b0;
    drive(1, 0, 1, 0, 0);
    #1;
    check("rst idle s_stb", {31'd0, s_stb_o}, 32'd0);
    @(negedge gclk);
    drive(1, 0, 1, 0, 1);
    #1;
    check("rst tie s_stb", {31'd0, s_stb_o}, 32'd1);
    check("rst tie s_adr", {2'd0, s_adr_o}, {2'd0, A0});
    check("rst tie m0_ack", {31'd0, m0_ack_o}, 32'd1);
    check("rst tie m1_ack", {31'd0, m1_ack_o}, 32'd0);
    @(negedge gclk);
    drive(0, 0, 0, 0, 0);

    // Slave never acks
    @(negedge gclk);
    drive(1, 0, 0, 0, 0);
`ifdef AEMB_DWB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      @(negedge gclk);
      #1;
      check($sformatf("tmo c%0d m0_err", c), {31'd0, m0_err_o}, {31'd0, c == 16});
      check($sformatf("tmo c%0d s_stb", c), {31'd0, s_stb_o}, {31'd0, c != 16});
    end
    @(negedge gclk);
    #1;
    check("tmo after err", {31'd0, m0_err_o}, 32'd0);
    check("tmo after s_stb", {31'd0, s_stb_o}, 32'd0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge gclk);
      s_ack_i = (c == 16);
      #1;
      check($sformatf("tmoack c%0d m0_ack", c), {31'd0, m0_ack_o}, {31'd0, c == 16});
      check($sformatf("tmoack c%0d m0_err", c), {31'd0, m0_err_o}, 32'd0);
      check($sformatf("tmoack c%0d s_stb", c), {31'd0, s_stb_o}, 32'd1);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge gclk);
      s_ack_i = (c == 20);
      #1;
      check($sformatf("noto c%0d m0_err", c), {31'd0, m0_err_o}, 32'd0);
      check($sformatf("noto c%0d s_stb", c), {31'd0, s_stb_o}, 32'd1);
      check($sformatf("noto c%0d m0_ack", c), {31'd0, m0_ack_o}, {31'd0, c == 20});
    end
`endif
    @(negedge gclk);
    drive(0, 0, 0, 0, 0);
    #1;
    check("final s_stb", {31'd0, s_stb_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
